jk_bank_arbiter: RTL



---
 rtl/jk_pkg.sv | 18 +
 rtl/jk_cell.sv | 24 ++
 rtl/jk_bank_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared op and FSM state types for the JK bank arbiter
package jk_pkg;

    // JK operation encoding as {j,k}
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_e;

    // Sequencer state
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } jk_state_e;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single synchronous JK flip-flop with asynchronous clear
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK update: 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - two-requester arbiter/sequencer over a bank of JK cells (JKA_RR_EN: round-robin grant)
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [IDXW-1:0]  req0_idx,
    input  logic [CNTW-1:0]  req0_cnt,
    output logic             req0_done,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [IDXW-1:0]  req1_idx,
    input  logic [CNTW-1:0]  req1_cnt,
    output logic             req1_done,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    jk_state_e       state_q;
    jk_op_e          op_q;
    logic [IDXW-1:0] idx_q;
    logic [CNTW-1:0] rem_q;
    logic            owner_q;
    logic            busy_q;
    logic            done0_q;
    logic            done1_q;
`ifdef JKA_RR_EN
    logic            ptr_q;     // requester granted most recently
`endif

    logic             sel1_d;   // arbiter pick: 1 selects requester 1
    logic             acc0;
    logic             acc1;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    // Arbitration and combinational ready; readys are held low while in reset
    always_comb begin
        sel1_d = req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef JKA_RR_EN
            sel1_d = ~ptr_q;
`else
            sel1_d = 1'b0;
`endif
        end
        req0_ready = (state_q == S_IDLE) && !reset && req0_valid && !sel1_d;
        req1_ready = (state_q == S_IDLE) && !reset && req1_valid &&  sel1_d;
    end

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    // Sequencer: latch the granted command, count applications, pulse done on the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= JK_HOLD;
            idx_q   <= '0;
            rem_q   <= '0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef JKA_RR_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (acc0 || acc1) begin
                        state_q <= S_APPLY;
                        busy_q  <= 1'b1;
                        owner_q <= acc1;
                        op_q    <= jk_op_e'(acc1 ? req1_op : req0_op);
                        idx_q   <= acc1 ? req1_idx : req0_idx;
                        rem_q   <= acc1 ? req1_cnt : req0_cnt;
`ifdef JKA_RR_EN
                        ptr_q   <= acc1;
`endif
                    end
                end
                S_APPLY: begin
                    if (rem_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done0_q <= ~owner_q;
                        done1_q <=  owner_q;
                    end else begin
                        rem_q <= rem_q - CNTW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Drive J/K only on the addressed cell; an out-of-range index matches no cell
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (state_q == S_APPLY) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (idx_q == IDXW'(i)) begin
                    j_vec[i] = op_q[1];
                    k_vec[i] = op_q[0];
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_vec[g]),
            .k     (k_vec[g]),
            .q     (q[g])
        );
    end

    assign busy      = busy_q;
    assign req0_done = done0_q;
    assign req1_done = done1_q;

endmodule
